// File: rtl/ili9341_spi_receiver.sv
// ILI9341-style SPI display receiver: deserialises command/data bytes, tracks the
// CASET/PASET window and turns RAMWR data into RGB565 frame-buffer writes.
module ili9341_spi_receiver #(
    parameter int COLS = 240,
    parameter int ROWS = 320
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        tftChipSelect,
    input  logic        tftSck,
    input  logic        tftMosi,
    input  logic        dataCtrl,
    output logic        pixelWe,
    output logic [16:0] pixelAddr,
    output logic [15:0] pixelDataOut,
    output logic        cmdStrobe,
    output logic [7:0]  cmdByte,
    output logic        frameDone
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [15:0] COL_MAX = 16'(COLS - 1);
    localparam logic [15:0] ROW_MAX = 16'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CASET_P  = 3'd1,
        PASET_P  = 3'd2,
        RAMWR_HI = 3'd3,
        RAMWR_LO = 3'd4,
        IGNORE   = 3'd5
    } decState_t;

    logic [1:0]       csSync_r, sckSync_r, mosiSync_r, dcSync_r;
    logic             sckPrev_r;
    logic             sckRise_s;
    logic [2:0]       bitCnt_r;
    logic [6:0]       shift_r;
    logic             byteValid_r;
    logic [7:0]       rxByte_r;
    logic             byteDc_r;

    decState_t        state_r, nextState_s;
    logic             cmdLoad_s, paramTake_s, commit_s, hiTake_s, pixWrite_s;
    logic [1:0]       paramCnt_r;
    logic [7:0]       p0_r, p1_r, p2_r, hiByte_r;
    logic [15:0]      startW_s, endRaw_s, maxW_s, endClamp_s;
    logic             commitOk_s;

    logic [COL_W-1:0] colStart_r, colEnd_r, col_r;
    logic [ROW_W-1:0] pageStart_r, pageEnd_r, page_r;
    logic             colLast_s, pageLast_s;
    logic [16:0]      addrNext_s;

    logic             pixelWe_r, cmdStrobe_r, frameDone_r;
    logic [16:0]      pixelAddr_r;
    logic [15:0]      pixelData_r;
    logic [7:0]       cmdByte_r;

    // Two-flop synchronisers for all SPI-side inputs plus the SCK edge history.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            csSync_r   <= 2'b11;
            sckSync_r  <= 2'b00;
            mosiSync_r <= 2'b00;
            dcSync_r   <= 2'b00;
            sckPrev_r  <= 1'b0;
        end else begin
            csSync_r   <= {csSync_r[0], tftChipSelect};
            sckSync_r  <= {sckSync_r[0], tftSck};
            mosiSync_r <= {mosiSync_r[0], tftMosi};
            dcSync_r   <= {dcSync_r[0], dataCtrl};
            sckPrev_r  <= sckSync_r[1];
        end
    end

    assign sckRise_s = sckSync_r[1] & ~sckPrev_r;

    // Byte assembly: CS high drops any partial byte so the next byte starts aligned.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            bitCnt_r    <= 3'd0;
            shift_r     <= 7'd0;
            byteValid_r <= 1'b0;
            rxByte_r    <= 8'd0;
            byteDc_r    <= 1'b0;
        end else if (csSync_r[1]) begin
            bitCnt_r    <= 3'd0;
            byteValid_r <= 1'b0;
        end else if (sckRise_s) begin
            shift_r  <= {shift_r[5:0], mosiSync_r[1]};
            bitCnt_r <= bitCnt_r + 3'd1;
            if (bitCnt_r == 3'd7) begin
                byteValid_r <= 1'b1;
                rxByte_r    <= {shift_r, mosiSync_r[1]};
                byteDc_r    <= dcSync_r[1];
            end else begin
                byteValid_r <= 1'b0;
            end
        end else begin
            byteValid_r <= 1'b0;
        end
    end

    // Decoder state register.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Decoder next-state and per-byte action selection.
    always_comb begin
        nextState_s = state_r;
        cmdLoad_s   = 1'b0;
        paramTake_s = 1'b0;
        commit_s    = 1'b0;
        hiTake_s    = 1'b0;
        pixWrite_s  = 1'b0;
        if (byteValid_r) begin
            if (!byteDc_r) begin
                cmdLoad_s = 1'b1;
                case (rxByte_r)
                    8'h2A:   nextState_s = CASET_P;
                    8'h2B:   nextState_s = PASET_P;
                    8'h2C:   nextState_s = RAMWR_HI;
                    default: nextState_s = IGNORE;
                endcase
            end else begin
                case (state_r)
                    CASET_P, PASET_P: begin
                        paramTake_s = 1'b1;
                        if (paramCnt_r == 2'd3) begin
                            commit_s    = 1'b1;
                            nextState_s = IGNORE;
                        end else begin
                            nextState_s = state_r;
                        end
                    end
                    RAMWR_HI: begin
                        hiTake_s    = 1'b1;
                        nextState_s = RAMWR_LO;
                    end
                    RAMWR_LO: begin
                        pixWrite_s  = 1'b1;
                        nextState_s = RAMWR_HI;
                    end
                    default: nextState_s = state_r;
                endcase
            end
        end else begin
            nextState_s = state_r;
        end
    end

    // Window commit arithmetic and cursor address/wrap detection.
    always_comb begin
        startW_s   = {p0_r, p1_r};
        endRaw_s   = {p2_r, rxByte_r};
        maxW_s     = (state_r == CASET_P) ? COL_MAX : ROW_MAX;
        endClamp_s = (endRaw_s > maxW_s) ? maxW_s : endRaw_s;
        commitOk_s = (startW_s <= endClamp_s);
        colLast_s  = (col_r == colEnd_r);
        pageLast_s = (page_r == pageEnd_r);
        addrNext_s = 17'(page_r) * 17'(COLS) + 17'(col_r);
    end

    // Parameter capture, window registers and write cursor.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            paramCnt_r  <= 2'd0;
            p0_r        <= 8'd0;
            p1_r        <= 8'd0;
            p2_r        <= 8'd0;
            hiByte_r    <= 8'd0;
            colStart_r  <= '0;
            colEnd_r    <= COL_W'(COLS - 1);
            pageStart_r <= '0;
            pageEnd_r   <= ROW_W'(ROWS - 1);
            col_r       <= '0;
            page_r      <= '0;
        end else if (cmdLoad_s) begin
            paramCnt_r <= 2'd0;
            if (rxByte_r == 8'h2C) begin
                col_r  <= colStart_r;
                page_r <= pageStart_r;
            end
        end else if (paramTake_s) begin
            paramCnt_r <= paramCnt_r + 2'd1;
            case (paramCnt_r)
                2'd0:    p0_r <= rxByte_r;
                2'd1:    p1_r <= rxByte_r;
                2'd2:    p2_r <= rxByte_r;
                default: p2_r <= p2_r;
            endcase
            if (commit_s && commitOk_s) begin
                if (state_r == CASET_P) begin
                    colStart_r <= COL_W'(startW_s);
                    colEnd_r   <= COL_W'(endClamp_s);
                end else begin
                    pageStart_r <= ROW_W'(startW_s);
                    pageEnd_r   <= ROW_W'(endClamp_s);
                end
            end
        end else if (hiTake_s) begin
            hiByte_r <= rxByte_r;
        end else if (pixWrite_s) begin
            if (colLast_s) begin
                col_r <= colStart_r;
                if (pageLast_s) begin
                    page_r <= pageStart_r;
                end else begin
                    page_r <= page_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Registered strobes and held output values.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            pixelWe_r   <= 1'b0;
            cmdStrobe_r <= 1'b0;
            frameDone_r <= 1'b0;
            cmdByte_r   <= 8'd0;
            pixelAddr_r <= 17'd0;
            pixelData_r <= 16'd0;
        end else begin
            pixelWe_r   <= pixWrite_s;
            cmdStrobe_r <= cmdLoad_s;
            frameDone_r <= pixWrite_s & colLast_s & pageLast_s;
            if (cmdLoad_s) begin
                cmdByte_r <= rxByte_r;
            end
            if (pixWrite_s) begin
                pixelAddr_r <= addrNext_s;
                pixelData_r <= {hiByte_r, rxByte_r};
            end
        end
    end

    assign pixelWe      = pixelWe_r;
    assign cmdStrobe    = cmdStrobe_r;
    assign frameDone    = frameDone_r;
    assign cmdByte      = cmdByte_r;
    assign pixelAddr    = pixelAddr_r;
    assign pixelDataOut = pixelData_r;

endmodule

// File: tb/tb_ili9341_spi_receiver.sv
// Scoreboard bench for ili9341_spi_receiver: expected pixel writes are queued as
// SPI bytes are driven and checked when pixelWe fires.
module tb_ili9341_spi_receiver;

    localparam int HALF = 4;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic        tftChipSelect = 1'b1;
    logic        tftSck = 1'b0;
    logic        tftMosi = 1'b0;
    logic        dataCtrl = 1'b0;
    logic        pixelWe;
    logic [16:0] pixelAddr;
    logic [15:0] pixelDataOut;
    logic        cmdStrobe;
    logic [7:0]  cmdByte;
    logic        frameDone;

    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
        logic        fd;
    } pix_t;

    pix_t expQ[$];
    pix_t mon_e;
    int   compared = 0;
    int   mismatched = 0;
    int   cmdCount = 0;
    int   writeCount = 0;

    ili9341_spi_receiver #(.COLS(240), .ROWS(320)) dut (
        .CLK_I        (CLK_I),
        .RST_I        (RST_I),
        .tftChipSelect(tftChipSelect),
        .tftSck       (tftSck),
        .tftMosi      (tftMosi),
        .dataCtrl     (dataCtrl),
        .pixelWe      (pixelWe),
        .pixelAddr    (pixelAddr),
        .pixelDataOut (pixelDataOut),
        .cmdStrobe    (cmdStrobe),
        .cmdByte      (cmdByte),
        .frameDone    (frameDone)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Output monitor: pop expected writes, count strobes.
    always @(negedge CLK_I) begin
        if (RST_I) begin
            if (cmdStrobe) cmdCount++;
            if (pixelWe) begin
                writeCount++;
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, required no write", pixelAddr, pixelDataOut);
                end else begin
                    mon_e = expQ.pop_front();
                    if (pixelAddr !== mon_e.addr || pixelDataOut !== mon_e.data || frameDone !== mon_e.fd) begin
                        mismatched++;
                        $display("FAIL pixel_write: got addr=%0d data=%h fd=%b, required addr=%0d data=%h fd=%b",
                                 pixelAddr, pixelDataOut, frameDone, mon_e.addr, mon_e.data, mon_e.fd);
                    end
                end
            end else if (frameDone) begin
                compared++;
                mismatched++;
                $display("FAIL stray_frameDone: frameDone=1 without pixelWe, required 0");
            end
        end
    end

    task automatic clk(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            tftMosi  = b[i];
            dataCtrl = dc;
            clk(HALF);
            tftSck = 1'b1;
            clk(HALF);
            tftSck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8);
    endtask

    task automatic send_cmd4(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] d, input logic [7:0] e);
        send_byte(c, 1'b0);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(d, 1'b1);
        send_byte(e, 1'b1);
    endtask

    task automatic send_pixel(input logic [15:0] data, input logic [16:0] addr, input logic fd);
        expQ.push_back('{addr, data, fd});
        send_byte(data[15:8], 1'b1);
        send_byte(data[7:0], 1'b1);
    endtask

    task automatic cs_begin();
        tftChipSelect = 1'b0;
        clk(4);
    endtask

    task automatic cs_end();
        clk(6);
        tftChipSelect = 1'b1;
        clk(4);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && expQ.size() > 0; i++) clk(1);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL drain_%s: %0d writes outstanding, required 0", name, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_reset();
        RST_I = 1'b0;
        clk(3);
        compared++;
        if (pixelWe !== 1'b0 || cmdStrobe !== 1'b0 || frameDone !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_strobes: we=%b cmd=%b fd=%b, required 0", pixelWe, cmdStrobe, frameDone);
        end
        compared++;
        if (pixelAddr !== 17'd0 || pixelDataOut !== 16'd0 || cmdByte !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_values: addr=%0d data=%h cmd=%h, required 0", pixelAddr, pixelDataOut, cmdByte);
        end
        RST_I = 1'b1;
        clk(3);
        cmdCount = 0;
        cs_begin();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        cs_end();
        compared++;
        if (cmdCount !== 0 || writeCount !== 0) begin
            mismatched++;
            $display("FAIL idle_data: cmds=%0d writes=%0d, required 0/0", cmdCount, writeCount);
        end
    endtask

    task automatic test_ramwr_basic();
        cmdCount = 0;
        cs_begin();
        send_byte(8'h2C, 1'b0);
        send_pixel(16'hF800, 17'd0, 1'b0);
        send_pixel(16'h07E0, 17'd1, 1'b0);
        cs_end();
        drain("ramwr_basic");
        compared++;
        if (cmdCount !== 1 || cmdByte !== 8'h2C) begin
            mismatched++;
            $display("FAIL ramwr_cmd: count=%0d byte=%h, required 1/2c", cmdCount, cmdByte);
        end
    endtask

    task automatic test_window();
        cs_begin();
        send_cmd4(8'h2A, 8'd0, 8'd10, 8'd0, 8'd11);
        send_cmd4(8'h2B, 8'd0, 8'd5, 8'd0, 8'd6);
        send_byte(8'h2C, 1'b0);
        send_pixel(16'h1111, 17'd1210, 1'b0);
        send_pixel(16'h2222, 17'd1211, 1'b0);
        send_pixel(16'h3333, 17'd1450, 1'b0);
        send_pixel(16'h4444, 17'd1451, 1'b1);
        send_pixel(16'h5555, 17'd1210, 1'b0);
        cs_end();
        drain("window");
    endtask

    task automatic test_window_invalid();
        RST_I = 1'b0;
        clk(2);
        RST_I = 1'b1;
        clk(2);
        cs_begin();
        send_cmd4(8'h2A, 8'd0, 8'd20, 8'd0, 8'd10);
        send_byte(8'h2C, 1'b0);
        send_pixel(16'hA5A5, 17'd0, 1'b0);
        send_cmd4(8'h2A, 8'd0, 8'd230, 8'h01, 8'h00);
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < 10; i++) send_pixel(16'h1000 + 16'(i), 17'(230 + i), 1'b0);
        send_pixel(16'hBEEF, 17'd470, 1'b0);
        cs_end();
        drain("window_clamp");
    endtask

    task automatic test_partial_cmd();
        cmdCount = 0;
        cs_begin();
        send_bits(8'h2C, 1'b0, 5);
        cs_end();
        cs_begin();
        send_byte(8'h2A, 1'b0);
        cs_end();
        compared++;
        if (cmdCount !== 1 || cmdByte !== 8'h2A) begin
            mismatched++;
            $display("FAIL partial_cmd: count=%0d byte=%h, required 1/2a", cmdCount, cmdByte);
        end
    endtask

    task automatic test_abort_hi();
        int w0;
        w0 = writeCount;
        cmdCount = 0;
        cs_begin();
        send_byte(8'h2C, 1'b0);
        send_byte(8'hAB, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'hCD, 1'b1);
        cs_end();
        compared++;
        if (writeCount !== w0 || cmdCount !== 2 || cmdByte !== 8'h00) begin
            mismatched++;
            $display("FAIL abort_hi: writes=%0d cmds=%0d byte=%h, required %0d/2/00",
                     writeCount - w0, cmdCount, cmdByte, 0);
        end
    endtask

    task automatic test_reset_midframe();
        cs_begin();
        send_cmd4(8'h2A, 8'd0, 8'd10, 8'd0, 8'd11);
        send_byte(8'h2C, 1'b0);
        send_pixel(16'h1234, 17'd10, 1'b0);
        drain("pre_reset");
        send_byte(8'h55, 1'b1);
        send_bits(8'h2C, 1'b0, 3);
        RST_I = 1'b0;
        #1;
        compared++;
        if (pixelAddr !== 17'd0 || pixelDataOut !== 16'd0 || cmdByte !== 8'd0 ||
            pixelWe !== 1'b0 || cmdStrobe !== 1'b0 || frameDone !== 1'b0) begin
            mismatched++;
            $display("FAIL midframe_reset: addr=%0d data=%h cmd=%h we=%b, required all 0",
                     pixelAddr, pixelDataOut, cmdByte, pixelWe);
        end
        clk(2);
        RST_I = 1'b1;
        clk(2);
        send_byte(8'h2C, 1'b0);
        send_pixel(16'h0001, 17'd0, 1'b0);
        send_pixel(16'h0002, 17'd1, 1'b0);
        send_pixel(16'h0003, 17'd2, 1'b0);
        cs_end();
        drain("post_reset");
        compared++;
        if (cmdByte !== 8'h2C) begin
            mismatched++;
            $display("FAIL post_reset_cmd: byte=%h, required 2c", cmdByte);
        end
    endtask

    initial begin
        test_reset();
        test_ramwr_basic();
        test_window();
        test_window_invalid();
        test_partial_cmd();
        test_abort_hi();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
